// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: shared state encoding, BCD limits, repeat defaults and BCD increment
//   Holds the setting-state enum, the hour/minute/second limits in packed BCD,
//   the default auto-repeat timing and the BCD increment-with-limit helper.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;

    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;

    // Anything that is not valid BCD, or is at/above the limit, rolls to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= lim) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_conditioner.sv
// btn_conditioner: button synchronizer, rising-edge detect and optional auto-repeat
//   clk     : system clock
//   rst_n   : asynchronous active-low clear
//   tick    : 1 kHz one-clk enable strobe used to time auto-repeat
//   btn     : asynchronous debounced button level
//   enable  : auto-repeat allowed (owner is in a state that accepts repeats)
//   clear   : restart the repeat timer (owner changed state this cycle)
//   pulse   : one-clk event for a new press or a repeat
module btn_conditioner
    import time_set_ctrl_pkg::*;
#(
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    input  logic enable,
    input  logic clear,
    output logic pulse
);

    localparam int CW = $clog2(REPEAT_DELAY + 1);

    // sync[1:0] is the two-flop synchronizer; sync[2] is the previous synchronized level.
    logic [2:0]    sync;
    logic [CW-1:0] cnt;
    logic          held;
    logic          fire;

    assign held  = REPEAT_EN && sync[1] && enable && !clear;
    assign fire  = held && tick && cnt == CW'(REPEAT_DELAY - 1);
    assign pulse = (sync[1] && !sync[2]) || fire;

    // After the first repeat the counter reloads so the next fires REPEAT_RATE ticks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[1:0], btn};
            cnt  <= !held ? '0 : !tick ? cnt : fire ? CW'(REPEAT_DELAY - REPEAT_RATE) : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: clock time-setting controller with mode/inc buttons and auto-repeat
//   clk                         : system clock
//   _CR                         : asynchronous active-low clear
//   tick_1k                     : 1 kHz one-clk enable strobe
//   btn_mode, btn_inc           : debounced button levels (asynchronous)
//   cur_hour, cur_min, cur_sec  : live packed BCD time
//   pre_hour, pre_min, pre_sec  : packed BCD preset values for the counters
//   PE                          : preset enable, high while editing
//   set_field                   : current state code (RUN/SET_HOUR/SET_MIN/SET_SEC)
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic       clk,
    input  logic       _CR,
    input  logic       tick_1k,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] pre_hour,
    output logic [7:0] pre_min,
    output logic [7:0] pre_sec,
    output logic       PE,
    output logic [1:0] set_field
);

    state_t state;
    logic   mode_p;
    logic   inc_p;

    btn_conditioner #(.REPEAT_EN(1'b0)) u_mode (
        .clk    (clk),
        .rst_n  (_CR),
        .tick   (tick_1k),
        .btn    (btn_mode),
        .enable (1'b0),
        .clear  (1'b0),
        .pulse  (mode_p)
    );

    btn_conditioner #(
        .REPEAT_EN    (1'b1),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_inc (
        .clk    (clk),
        .rst_n  (_CR),
        .tick   (tick_1k),
        .btn    (btn_inc),
        .enable (state != RUN),
        .clear  (mode_p),
        .pulse  (inc_p)
    );

    assign set_field = state;

    // A mode event outranks an inc event in the same cycle; the inc is dropped.
    always_ff @(posedge clk or negedge _CR) begin
        if (!_CR) begin
            state    <= RUN;
            PE       <= 1'b0;
            pre_hour <= 8'h00;
            pre_min  <= 8'h00;
            pre_sec  <= 8'h00;
        end else if (mode_p) begin
            state <= state_t'(state + 2'd1);
            PE    <= state != SET_SEC;
            if (state == RUN) begin
                pre_hour <= cur_hour;
                pre_min  <= cur_min;
                pre_sec  <= cur_sec;
            end
        end else if (inc_p) begin
            if (state == SET_HOUR) pre_hour <= bcd_inc(pre_hour, HOUR_MAX);
            if (state == SET_MIN)  pre_min  <= bcd_inc(pre_min, MS_MAX);
            if (state == SET_SEC)  pre_sec  <= bcd_inc(pre_sec, MS_MAX);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: randomized self-checking bench for time_set_ctrl against a decimal reference model
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       cr_n = 1'b0;
    logic       tick_1k = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] cur_hour = 8'h00;
    logic [7:0] cur_min = 8'h00;
    logic [7:0] cur_sec = 8'h00;
    logic [7:0] pre_hour;
    logic [7:0] pre_min;
    logic [7:0] pre_sec;
    logic       PE;
    logic [1:0] set_field;

    int errors = 0;
    int checks = 0;

    // Reference model: state as 0..3, preset fields as BCD bytes (index 0=hour,1=min,2=sec).
    int         m_state = 0;
    logic [7:0] m_pre [3] = '{8'h00, 8'h00, 8'h00};

    time_set_ctrl dut (
        .clk       (clk),
        ._CR       (cr_n),
        .tick_1k   (tick_1k),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .pre_hour  (pre_hour),
        .pre_min   (pre_min),
        .pre_sec   (pre_sec),
        .PE        (PE),
        .set_field (set_field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] to_bcd(input int d);
        return 8'((d / 10) * 16 + d % 10);
    endfunction

    // Decimal-arithmetic increment: invalid digits or values at/over the limit go to 0.
    function automatic logic [7:0] m_inc(input logic [7:0] v, input int maxd);
        int hi;
        int lo;
        int d;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9 || lo > 9) return 8'h00;
        d = hi * 10 + lo;
        if (d >= maxd) return 8'h00;
        return to_bcd(d + 1);
    endfunction

    function automatic int field_max(input int st);
        return st == 1 ? 23 : 59;
    endfunction

    task automatic m_op(input bit m, input bit i);
        if (m) begin
            if (m_state == 0) begin
                m_pre[0] = cur_hour;
                m_pre[1] = cur_min;
                m_pre[2] = cur_sec;
            end
            m_state = (m_state + 1) % 4;
        end else if (i && m_state != 0) begin
            m_pre[m_state-1] = m_inc(m_pre[m_state-1], field_max(m_state));
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".field"}, {6'd0, set_field}, 8'(m_state));
        chk({tag, ".pe"}, {7'd0, PE}, {7'd0, m_state != 0});
        chk({tag, ".hour"}, pre_hour, m_pre[0]);
        chk({tag, ".min"}, pre_min, m_pre[1]);
        chk({tag, ".sec"}, pre_sec, m_pre[2]);
    endtask

    task automatic press(input bit m, input bit i);
        btn_mode = m;
        btn_inc = i;
        cyc(4);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        cyc(4);
        m_op(m, i);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_1k = 1'b1;
            cyc(1);
            tick_1k = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        cur_hour = h;
        cur_min = mi;
        cur_sec = s;
    endtask

    function automatic logic [7:0] rnd_field(input int maxd);
        return ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, maxd)));
    endfunction

    initial begin
        int n_rep;
        logic [7:0] exp_sec;
        set_cur(8'h11, 8'h22, 8'h33);
        cyc(3);
        check_all("reset");
        cr_n = 1'b1;
        cyc(3);
        check_all("post_reset");

        set_cur(8'h12, 8'h34, 8'h56);
        btn_mode = 1'b1;
        cyc(2);
        chk("enter.early_field", {6'd0, set_field}, 8'd0);
        chk("enter.early_pe", {7'd0, PE}, 8'd0);
        cyc(1);
        m_op(1'b1, 1'b0);
        check_all("enter.3cyc");
        btn_mode = 1'b0;
        cyc(4);
        check_all("enter.hold");

        press(1, 0);
        press(1, 0);
        press(1, 0);
        check_all("back_to_run");

        set_cur(8'h23, 8'h59, 8'h07);
        press(1, 0);
        press(0, 1);
        chk("hour_wrap", pre_hour, 8'h00);
        check_all("hour_wrap");
        press(1, 0);
        press(0, 1);
        chk("min_wrap", pre_min, 8'h00);
        check_all("min_wrap");
        press(1, 0);
        press(1, 0);
        check_all("four_presses_run");
        set_cur(8'h01, 8'h02, 8'h03);
        press(0, 1);
        check_all("inc_in_run");

        set_cur(8'h00, 8'h09, 8'h59);
        press(1, 0);
        press(1, 0);
        press(0, 1);
        chk("min_carry", pre_min, 8'h10);
        press(1, 1);
        chk("both.field", {6'd0, set_field}, 8'd3);
        chk("both.min", pre_min, 8'h10);
        check_all("both");

        // Edge press takes 59 -> 00, then repeats at held ticks 500, 600, 700, 800.
        btn_inc = 1'b1;
        cyc(3);
        m_op(1'b0, 1'b1);
        chk("hold.edge", pre_sec, 8'h00);
        tick_n(499);
        chk("hold.499", pre_sec, 8'h00);
        tick_n(1);
        chk("hold.500", pre_sec, 8'h01);
        tick_n(300);
        btn_inc = 1'b0;
        n_rep = 1 + (800 - 500) / 100;
        exp_sec = m_pre[2];
        repeat (n_rep) exp_sec = m_inc(exp_sec, 59);
        m_pre[2] = exp_sec;
        cyc(4);
        chk("hold.800", pre_sec, 8'h04);
        check_all("hold.done");

        press(1, 0);
        check_all("exit_run");
        press(1, 0);
        press(1, 0);
        btn_inc = 1'b1;
        cyc(6);
        cr_n = 1'b0;
        #1;
        chk("async.pe", {7'd0, PE}, 8'd0);
        chk("async.field", {6'd0, set_field}, 8'd0);
        chk("async.hour", pre_hour, 8'h00);
        chk("async.min", pre_min, 8'h00);
        chk("async.sec", pre_sec, 8'h00);
        m_state = 0;
        m_pre = '{8'h00, 8'h00, 8'h00};
        cyc(3);
        cr_n = 1'b1;
        cyc(12);
        check_all("after_reset_held");
        btn_inc = 1'b0;
        cyc(4);

        for (int k = 0; k < 60; k++) begin
            int op;
            set_cur(rnd_field(23), rnd_field(59), rnd_field(59));
            op = int'($urandom_range(0, 4));
            press(op == 0 || op == 2, op != 0);
            check_all($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
